// File: rtl/scr1_dmem_pkg.sv
// DMEM interface encodings shared by the LSU and its memory targets.
package scr1_dmem_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10,
    SCR1_MEM_WIDTH_ERROR = 2'b11
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

endpackage

// File: rtl/scr1_dmem_responder.sv
// DMEM target: one request at a time, fixed-latency single-cycle response.
// Ack is high only in IDLE; requests seen while BUSY wait until the next IDLE.
module scr1_dmem_responder
  import scr1_dmem_pkg::*;
#(
  parameter int                          SCR1_DMEM_AWIDTH = 32,
  parameter int                          SCR1_DMEM_DWIDTH = 32,
  parameter int                          SIZE_BYTES       = 4096,
  parameter logic [SCR1_DMEM_AWIDTH-1:0] BASE_ADDR        = '0,
  parameter int                          LATENCY          = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        dmem_req,
  input  type_scr1_mem_cmd_e          dmem_cmd,
  input  type_scr1_mem_width_e        dmem_width,
  input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr,
  input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata,
  output logic                        dmem_req_ack,
  output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata,
  output type_scr1_mem_resp_e         dmem_resp
);

  localparam int OFFW  = $clog2(SIZE_BYTES);
  localparam int IW    = (OFFW > 2) ? OFFW - 2 : 1;
  localparam int DEPTH = SIZE_BYTES / 4;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e                      r_state, w_state_nxt;
  logic [3:0]                  r_cnt, w_cnt_nxt;
  logic                        w_ack, w_accept;

  type_scr1_mem_cmd_e          r_cmd;
  type_scr1_mem_width_e        r_width;
  logic [OFFW-1:0]             r_off;
  logic [SCR1_DMEM_DWIDTH-1:0] r_wdata;
  logic                        r_err;

  logic [SCR1_DMEM_AWIDTH-1:0] w_off;
  logic                        w_err;
  logic                        w_resp_cyc, w_we;
  logic [IW-1:0]               w_idx;
  logic [31:0]                 w_word, w_rdata, w_wdat;
  logic [3:0]                  w_be;

  logic [31:0]                 r_mem [DEPTH];

  // Modulo subtraction makes addresses below BASE_ADDR look huge, so one compare covers both ends.
  assign w_off = dmem_addr - BASE_ADDR;

  always_comb begin
    w_err = (w_off >= SCR1_DMEM_AWIDTH'(SIZE_BYTES));
    case (dmem_width)
      SCR1_MEM_WIDTH_BYTE:  ;
      SCR1_MEM_WIDTH_HWORD: if (dmem_addr[0]) w_err = 1'b1;
      SCR1_MEM_WIDTH_WORD:  if (dmem_addr[1:0] != 2'b00) w_err = 1'b1;
      default:              w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ack       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ack = ~rst;
        if (dmem_req && !rst) begin
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_accept     = dmem_req & w_ack;
  assign dmem_req_ack = w_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd   <= SCR1_MEM_CMD_RD;
      r_width <= SCR1_MEM_WIDTH_BYTE;
      r_off   <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_cmd   <= dmem_cmd;
      r_width <= dmem_width;
      r_off   <= w_off[OFFW-1:0];
      r_wdata <= dmem_wdata;
      r_err   <= w_err;
    end
  end

  assign w_resp_cyc = (r_state == ST_BUSY) && (r_cnt == 4'd0);
  assign w_we       = w_resp_cyc && !r_err && (r_cmd == SCR1_MEM_CMD_WR);
  assign w_idx      = IW'(r_off >> 2);
  assign w_word     = r_mem[w_idx];

  always_comb begin
    w_rdata = '0;
    w_be    = 4'b0000;
    w_wdat  = r_wdata;
    case (r_width)
      SCR1_MEM_WIDTH_BYTE: begin
        w_rdata = {24'd0, w_word[{r_off[1:0], 3'b000} +: 8]};
        w_be    = 4'b0001 << r_off[1:0];
        w_wdat  = {4{r_wdata[7:0]}};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        w_rdata = {16'd0, w_word[{r_off[1], 4'b0000} +: 16]};
        w_be    = r_off[1] ? 4'b1100 : 4'b0011;
        w_wdat  = {2{r_wdata[15:0]}};
      end
      SCR1_MEM_WIDTH_WORD: begin
        w_rdata = w_word;
        w_be    = 4'b1111;
      end
      default: ;
    endcase
  end

  // Array is deliberately not reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
      end
    end
  end

  always_comb begin
    dmem_resp  = SCR1_MEM_RESP_NOTRDY;
    dmem_rdata = '0;
    if (w_resp_cyc) begin
      if (r_err) begin
        dmem_resp = SCR1_MEM_RESP_RDY_ER;
      end else begin
        dmem_resp = SCR1_MEM_RESP_RDY_OK;
        if (r_cmd == SCR1_MEM_CMD_RD) dmem_rdata = w_rdata;
      end
    end
  end

endmodule

// File: tb/tb_scr1_dmem_responder.sv
// Directed bench: three responder instances (LATENCY=1 base 0, LATENCY=1 base 0x1000, LATENCY=3 base 0).
module tb_scr1_dmem_responder;
  import scr1_dmem_pkg::*;

  localparam type_scr1_mem_cmd_e   RD = SCR1_MEM_CMD_RD;
  localparam type_scr1_mem_cmd_e   WR = SCR1_MEM_CMD_WR;
  localparam type_scr1_mem_width_e B  = SCR1_MEM_WIDTH_BYTE;
  localparam type_scr1_mem_width_e H  = SCR1_MEM_WIDTH_HWORD;
  localparam type_scr1_mem_width_e W  = SCR1_MEM_WIDTH_WORD;
  localparam type_scr1_mem_width_e BAD = SCR1_MEM_WIDTH_ERROR;
  localparam logic [1:0] R_IDLE = 2'b00;
  localparam logic [1:0] R_OK   = 2'b01;
  localparam logic [1:0] R_ER   = 2'b10;

  logic                 clk;
  logic                 rst   [3];
  logic                 req   [3];
  type_scr1_mem_cmd_e   cmd   [3];
  type_scr1_mem_width_e wid   [3];
  logic [31:0]          addr  [3];
  logic [31:0]          wdata [3];
  logic                 ack   [3];
  logic [31:0]          rdata [3];
  type_scr1_mem_resp_e  resp  [3];

  int n_cmp = 0;
  int n_err = 0;

  scr1_dmem_responder #(.SIZE_BYTES(4096), .BASE_ADDR(32'h0), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst[0]), .dmem_req(req[0]), .dmem_cmd(cmd[0]), .dmem_width(wid[0]),
    .dmem_addr(addr[0]), .dmem_wdata(wdata[0]), .dmem_req_ack(ack[0]),
    .dmem_rdata(rdata[0]), .dmem_resp(resp[0]));

  scr1_dmem_responder #(.SIZE_BYTES(4096), .BASE_ADDR(32'h1000), .LATENCY(1)) u_rg (
    .clk(clk), .rst(rst[1]), .dmem_req(req[1]), .dmem_cmd(cmd[1]), .dmem_width(wid[1]),
    .dmem_addr(addr[1]), .dmem_wdata(wdata[1]), .dmem_req_ack(ack[1]),
    .dmem_rdata(rdata[1]), .dmem_resp(resp[1]));

  scr1_dmem_responder #(.SIZE_BYTES(4096), .BASE_ADDR(32'h0), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst[2]), .dmem_req(req[2]), .dmem_cmd(cmd[2]), .dmem_width(wid[2]),
    .dmem_addr(addr[2]), .dmem_wdata(wdata[2]), .dmem_req_ack(ack[2]),
    .dmem_rdata(rdata[2]), .dmem_resp(resp[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request on instance d and check ack, latency, response, data and the idle cycle after.
  task automatic access(input int d, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                        input logic [31:0] a, input logic [31:0] wd, input int exp_lat,
                        input logic [1:0] exp_resp, input logic chk_data, input logic [31:0] exp_data,
                        input string tag);
    int waits;
    int lat;
    @(negedge clk);
    req[d] = 1'b1; cmd[d] = c; wid[d] = w; addr[d] = a; wdata[d] = wd;
    waits = 0;
    while (!ack[d] && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check({tag, " ack_wait"}, waits, 0);
    @(posedge clk);
    #1 req[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (resp[d] == SCR1_MEM_RESP_NOTRDY && lat < 20);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " resp"}, {30'd0, resp[d]}, {30'd0, exp_resp});
    if (chk_data) check({tag, " rdata"}, rdata[d], exp_data);
    @(negedge clk);
    check({tag, " resp_after"}, {30'd0, resp[d]}, {30'd0, R_IDLE});
    check({tag, " rdata_after"}, rdata[d], 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; cmd[i] = RD; wid[i] = W; addr[i] = '0; wdata[i] = '0;
    end
    // u_l1 holds a request across reset deassertion
    req[0] = 1'b1; addr[0] = 32'h4;

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst ack", {31'd0, ack[i]}, 32'h0);
      check("rst resp", {30'd0, resp[i]}, {30'd0, R_IDLE});
      check("rst rdata", rdata[i], 32'h0);
    end
    @(posedge clk);
    #1 for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    @(negedge clk);
    check("post_rst ack", {31'd0, ack[0]}, 32'h1);
    @(posedge clk);
    #1 req[0] = 1'b0;
    @(negedge clk);
    check("post_rst resp", {30'd0, resp[0]}, {30'd0, R_OK});

    // Basic word write/read at LATENCY=1
    access(0, WR, W, 32'h10, 32'hDEAD_BEEF, 1, R_OK, 1'b1, 32'h0, "wr_word");
    access(0, RD, W, 32'h10, 32'h0,         1, R_OK, 1'b1, 32'hDEAD_BEEF, "rd_word");

    // Sub-word lanes
    access(0, RD, B, 32'h10, 32'h0,         1, R_OK, 1'b1, 32'h0000_00EF, "rd_byte0");
    access(0, RD, H, 32'h10, 32'h0,         1, R_OK, 1'b1, 32'h0000_BEEF, "rd_half0");
    access(0, WR, B, 32'h13, 32'h0000_00A5, 1, R_OK, 1'b1, 32'h0, "wr_byte3");
    access(0, RD, B, 32'h13, 32'h0,         1, R_OK, 1'b1, 32'h0000_00A5, "rd_byte3");
    access(0, RD, H, 32'h12, 32'h0,         1, R_OK, 1'b1, 32'h0000_A5AD, "rd_half2");
    access(0, RD, W, 32'h10, 32'h0,         1, R_OK, 1'b1, 32'hA5AD_BEEF, "rd_word2");

    // Misalignment and invalid width leave the array untouched
    access(0, WR, W,   32'h12, 32'h1111_1111, 1, R_ER, 1'b1, 32'h0, "mis_wr_word");
    access(0, RD, H,   32'h11, 32'h0,         1, R_ER, 1'b1, 32'h0, "mis_rd_half");
    access(0, RD, BAD, 32'h10, 32'h0,         1, R_ER, 1'b1, 32'h0, "bad_width");
    access(0, WR, H,   32'h10, 32'h2222_7777, 1, R_OK, 1'b1, 32'h0, "wr_half0");
    access(0, RD, W,   32'h10, 32'h0,         1, R_OK, 1'b1, 32'hA5AD_7777, "rd_after_err");

    // Range check with BASE_ADDR=0x1000
    access(1, RD, W, 32'h2000, 32'h0,         1, R_ER, 1'b1, 32'h0, "rng_above");
    access(1, WR, W, 32'h0FFC, 32'h5555_5555, 1, R_ER, 1'b1, 32'h0, "rng_below");
    access(1, WR, W, 32'h1FFC, 32'h0BAD_F00D, 1, R_OK, 1'b1, 32'h0, "rng_last_wr");
    access(1, RD, W, 32'h1FFC, 32'h0,         1, R_OK, 1'b1, 32'h0BAD_F00D, "rng_last_rd");

    // LATENCY=3: baseline contents, then cycle-accurate window with req held high
    access(2, WR, W, 32'h20, 32'hCAFE_F00D, 3, R_OK, 1'b1, 32'h0, "l3_wr");
    @(negedge clk);
    req[2] = 1'b1; cmd[2] = RD; wid[2] = W; addr[2] = 32'h20;
    check("l3 issue ack", {31'd0, ack[2]}, 32'h1);
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check($sformatf("l3 ack c%0d", i), {31'd0, ack[2]}, (i == 4) ? 32'h1 : 32'h0);
      check($sformatf("l3 resp c%0d", i), {30'd0, resp[2]}, (i == 3) ? {30'd0, R_OK} : {30'd0, R_IDLE});
      if (i == 3) check("l3 rdata", rdata[2], 32'hCAFE_F00D);
      if (i == 4) req[2] = 1'b0;
    end

    // Reset mid-write drops the pending store
    @(negedge clk);
    req[2] = 1'b1; cmd[2] = WR; wid[2] = W; addr[2] = 32'h20; wdata[2] = 32'h1234_5678;
    check("rstmid issue ack", {31'd0, ack[2]}, 32'h1);
    @(posedge clk);
    #1 req[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b1;
    #1 check("rstmid ack in rst", {31'd0, ack[2]}, 32'h0);
    @(posedge clk);
    #1 rst[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("rstmid ack after", {31'd0, ack[2]}, 32'h1);
      check($sformatf("rstmid resp c%0d", i), {30'd0, resp[2]}, {30'd0, R_IDLE});
    end
    access(2, RD, W, 32'h20, 32'h0, 3, R_OK, 1'b1, 32'hCAFE_F00D, "rstmid_rd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
